// File: rtl/tsu_axis_tx_stamp.sv
// tsu_axis_tx_stamp: transmit-side timestamp stage in front of the tri-mode MAC.
// Frames pass through a 2-entry skid buffer. The RTC is captured when the MAC
// accepts byte 0 of each frame, and a report is issued when the frame's last
// byte is accepted. With TSU_TX_INSERT_EN defined, frames carrying ETHERTYPE
// have 8 bytes starting at TS_OFFSET overwritten with the capture, MSB first.
// TS_OFFSET must lie in 16..2039 so that byte 0 has left the buffer before the
// first stamped byte is pushed.
module tsu_axis_tx_stamp #(
    parameter logic [15:0] ETHERTYPE = 16'h88F7,
    parameter int          TS_OFFSET = 48
) (
    input  logic        mac_axis_aclk,
    input  logic        rst,
    input  logic [63:0] rtc_timer_in,
    input  logic [7:0]  mac_axis_tdata,
    input  logic        mac_axis_tvalid,
    input  logic        mac_axis_tlast,
    output logic        mac_axis_tready,
    output logic [7:0]  mac_axis_out_tdata,
    output logic        mac_axis_out_tvalid,
    output logic        mac_axis_out_tlast,
    input  logic        mac_axis_out_tready,
    output logic [63:0] tx_ts,
    output logic        tx_ts_match,
    output logic        tx_ts_valid
);

    localparam logic [10:0] CNT_MAX = 11'd2047;
    localparam logic [10:0] ETH_LO  = 11'd12;
    localparam logic [10:0] ETH_HI  = 11'd13;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY} state_t;

    // Byte counter increment that sticks at its maximum instead of wrapping.
    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CNT_MAX) ? v : v + 11'd1;
    endfunction

    logic        push;
    logic        pop;
    logic [1:0]  count;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [7:0]  buf_data [2];
    logic        buf_last [2];
    logic        buf_mt   [2];
    logic        head_last;
    logic        head_mt;
    logic [10:0] in_cnt;
    state_t      state;
    state_t      state_nxt;
    logic        hdr_phase;
    logic [7:0]  b12;
    logic        match;
    logic        match_now;
    logic [7:0]  push_data;
    logic        sof;
    logic [63:0] ts_cap;

    assign push                = mac_axis_tvalid && mac_axis_tready;
    assign pop                 = mac_axis_out_tvalid && mac_axis_out_tready;
    assign mac_axis_tready     = (count != 2'd2);
    assign mac_axis_out_tvalid = (count != 2'd0);
    assign mac_axis_out_tdata  = buf_data[rd_ptr];
    assign mac_axis_out_tlast  = buf_last[rd_ptr];
    assign head_last           = buf_last[rd_ptr];
    assign head_mt             = buf_mt[rd_ptr];

`ifdef TSU_TX_INSERT_EN
    localparam logic [10:0] INS_LO = 11'(TS_OFFSET);
    localparam logic [10:0] INS_HI = 11'(TS_OFFSET + 7);

    // Selects byte k of the timestamp, counting from the most significant byte.
    function automatic logic [7:0] ts_byte(input logic [63:0] ts, input logic [2:0] k);
        logic [63:0] sh;
        sh = ts << {k, 3'b000};
        return sh[63:56];
    endfunction

    logic [2:0] ins_k;
    assign ins_k = 3'(in_cnt - INS_LO);

    // Replace payload bytes inside the stamp field of matching frames.
    always_comb begin
        push_data = mac_axis_tdata;
        if (match && (in_cnt >= INS_LO) && (in_cnt <= INS_HI))
            push_data = ts_byte(ts_cap, ins_k);
    end
`else
    assign push_data = mac_axis_tdata;
`endif

    // Skid buffer storage and occupancy; each entry keeps its frame's match so
    // the report stays correct when the next frame has already started.
    always_ff @(posedge mac_axis_aclk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= 8'd0;
                buf_last[i] <= 1'b0;
                buf_mt[i]   <= 1'b0;
            end
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= push_data;
                buf_last[wr_ptr] <= mac_axis_tlast;
                buf_mt[wr_ptr]   <= match_now;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Input byte index within the current frame.
    always_ff @(posedge mac_axis_aclk or posedge rst) begin
        if (rst)
            in_cnt <= 11'd0;
        else if (push)
            in_cnt <= mac_axis_tlast ? 11'd0 : sat_inc(in_cnt);
    end

    // Input-side frame phase register.
    always_ff @(posedge mac_axis_aclk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Input-side frame phase transitions.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (push && !mac_axis_tlast) state_nxt = S_HDR;
            S_HDR: begin
                if (push && mac_axis_tlast)    state_nxt = S_IDLE;
                else if (push && in_cnt == ETH_HI) state_nxt = S_BODY;
            end
            S_BODY: if (push && mac_axis_tlast) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Header phase covers bytes 0..13, where the EtherType is examined.
    always_comb begin
        hdr_phase = (state != S_BODY);
    end

    // Match value for the byte being pushed: zero before byte 13, decided at 13.
    always_comb begin
        match_now = match;
        if (in_cnt < ETH_HI)
            match_now = 1'b0;
        else if (hdr_phase && in_cnt == ETH_HI)
            match_now = ({b12, mac_axis_tdata} == ETHERTYPE);
    end

    // EtherType high byte latch and per-frame match flag.
    always_ff @(posedge mac_axis_aclk or posedge rst) begin
        if (rst) begin
            b12   <= 8'd0;
            match <= 1'b0;
        end else if (push) begin
            if (hdr_phase && in_cnt == ETH_LO)
                b12 <= mac_axis_tdata;
            match <= match_now;
        end
    end

    // Output start-of-frame tracking and RTC capture at the first accepted byte.
    always_ff @(posedge mac_axis_aclk or posedge rst) begin
        if (rst) begin
            sof    <= 1'b1;
            ts_cap <= 64'd0;
        end else if (pop) begin
            sof <= head_last;
            if (sof)
                ts_cap <= rtc_timer_in;
        end
    end

    // Per-frame report; a one-byte frame takes the RTC directly since the
    // capture register is being loaded in the same cycle.
    always_ff @(posedge mac_axis_aclk or posedge rst) begin
        if (rst) begin
            tx_ts       <= 64'd0;
            tx_ts_match <= 1'b0;
            tx_ts_valid <= 1'b0;
        end else begin
            tx_ts_valid <= pop && head_last;
            if (pop && head_last) begin
                tx_ts       <= sof ? rtc_timer_in : ts_cap;
                tx_ts_match <= head_mt;
            end
        end
    end

endmodule

// File: tb/tb_tsu_axis_tx_stamp.sv
// Bench for tsu_axis_tx_stamp: table of frames plus back-to-back and reset sequences.
`timescale 1ns/1ps
module tb_tsu_axis_tx_stamp;

`ifdef TSU_TX_INSERT_EN
    localparam bit INS_EN = 1'b1;
`else
    localparam bit INS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] rtc;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic [7:0]  out_tdata;
    logic        out_tvalid;
    logic        out_tlast;
    logic        out_tready;
    logic [63:0] tx_ts;
    logic        tx_ts_match;
    logic        tx_ts_valid;

    tsu_axis_tx_stamp dut (
        .mac_axis_aclk      (clk),
        .rst                (rst),
        .rtc_timer_in       (rtc),
        .mac_axis_tdata     (tdata),
        .mac_axis_tvalid    (tvalid),
        .mac_axis_tlast     (tlast),
        .mac_axis_tready    (tready),
        .mac_axis_out_tdata (out_tdata),
        .mac_axis_out_tvalid(out_tvalid),
        .mac_axis_out_tlast (out_tlast),
        .mac_axis_out_tready(out_tready),
        .tx_ts              (tx_ts),
        .tx_ts_match        (tx_ts_match),
        .tx_ts_valid        (tx_ts_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         k;
    } exp_byte_t;

    typedef struct {
        int          len;
        logic [15:0] etype;
        int          rmode;
        logic [63:0] rtc0;
        bit          run;
        bit          exp_match;
        int          exp_ins;
    } vec_t;

    exp_byte_t   exp_q[$];
    bit          rep_q[$];
    logic [63:0] cap_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          rmode = 0;
    bit          rtc_run = 1'b0;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // RTC and MAC ready are changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rtc_run) rtc = rtc + 64'd3;
        case (rmode)
            0:       out_tready = 1'b1;
            1:       out_tready = ~out_tready;
            default: out_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: byte scoreboard, hold stability, per-frame report.
    bit          sof_m = 1'b1;
    bit          pend = 1'b0;
    bit          held_v = 1'b0;
    logic [7:0]  held_d;
    logic        held_l;
    logic [63:0] cur_cap = 64'd0;
    always @(negedge clk) begin
        exp_byte_t   e;
        logic [7:0]  ed;
        bit          em;
        logic [63:0] ec;
        if (rst) begin
            sof_m  = 1'b1;
            pend   = 1'b0;
            held_v = 1'b0;
        end else begin
            if (pend) begin
                chk("ts_valid_pulse", tx_ts_valid == 1'b1, 64'(tx_ts_valid), 64'd1);
                if (rep_q.size() > 0 && cap_q.size() > 0) begin
                    em = rep_q.pop_front();
                    ec = cap_q.pop_front();
                    chk("tx_ts", tx_ts == ec, tx_ts, ec);
                    chk("tx_ts_match", tx_ts_match == em, 64'(tx_ts_match), 64'(em));
                end else begin
                    chk("report_underflow", 1'b0, 64'd0, 64'd1);
                end
                pend = 1'b0;
            end else if (tx_ts_valid) begin
                chk("spurious_ts_valid", 1'b0, 64'd1, 64'd0);
            end
            if (held_v)
                chk("hold", out_tvalid == 1'b1 && out_tdata == held_d && out_tlast == held_l,
                    64'({out_tvalid, out_tlast, out_tdata}), 64'({1'b1, held_l, held_d}));
            held_v = out_tvalid && !out_tready;
            held_d = out_tdata;
            held_l = out_tlast;
            if (out_tvalid && out_tready) begin
                if (sof_m) begin
                    cur_cap = rtc;
                    cap_q.push_back(rtc);
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 1'b0, 64'(out_tdata), 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    ed = (e.k >= 0) ? 8'(cur_cap >> (8 * (7 - e.k))) : e.data;
                    chk("out_tdata", out_tdata == ed, 64'(out_tdata), 64'(ed));
                    chk("out_tlast", out_tlast == e.last, 64'(out_tlast), 64'(e.last));
                end
                sof_m = out_tlast;
                if (out_tlast) pend = 1'b1;
            end
        end
    end

    task automatic push_byte(input logic [7:0] d, input logic l);
        int g = 0;
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        @(negedge clk);
        while (!tready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) chk("push_timeout", 1'b0, 64'd0, 64'd1);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    // Sends bytes 0..nsend-1 of a len-byte frame; stamped bytes are those from
    // 48 up to 48+ins-1 when insertion is built.
    task automatic send_frame(input int len, input logic [15:0] et, input bit m,
                              input int ins, input int seed, input int nsend);
        rep_q.push_back(m);
        for (int i = 0; i < nsend; i++) begin
            exp_byte_t e;
            logic [7:0] d;
            bit st;
            d  = (i == 12) ? et[15:8] : (i == 13) ? et[7:0] : 8'(i * 7 + seed);
            st = (i >= 48) && (i < 48 + ins);
            e.data = d;
            e.last = (i == len - 1);
            e.k    = (INS_EN && st) ? i - 48 : -1;
            exp_q.push_back(e);
            push_byte(d, e.last);
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || rep_q.size() != 0 || pend) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("drain", g < 5000, 64'(g), 64'd5000);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[7];
        vt[0] = '{60,   16'h88F7, 0, 64'h0011223344556677, 1'b0, 1'b1, 8};
        vt[1] = '{60,   16'h0800, 0, 64'h0123456789ABCDEF, 1'b0, 1'b0, 0};
        vt[2] = '{52,   16'h88F7, 0, 64'hAABBCCDD11223344, 1'b0, 1'b1, 4};
        vt[3] = '{13,   16'h88F7, 0, 64'h0000000000005000, 1'b1, 1'b0, 0};
        vt[4] = '{14,   16'h88F7, 0, 64'h0000000000006000, 1'b1, 1'b1, 0};
        vt[5] = '{64,   16'h88F7, 2, 64'h0000000000007000, 1'b1, 1'b1, 8};
        vt[6] = '{2100, 16'h88F7, 0, 64'h0000000000008000, 1'b1, 1'b1, 8};

        tvalid = 1'b0; tdata = 8'd0; tlast = 1'b0; rtc = 64'd0; out_tready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_tvalid", out_tvalid == 1'b0, 64'(out_tvalid), 64'd0);
        chk("rst_out_tlast", out_tlast == 1'b0, 64'(out_tlast), 64'd0);
        chk("rst_out_tdata", out_tdata == 8'd0, 64'(out_tdata), 64'd0);
        chk("rst_tx_ts", tx_ts == 64'd0, tx_ts, 64'd0);
        chk("rst_tx_ts_match", tx_ts_match == 1'b0, 64'(tx_ts_match), 64'd0);
        chk("rst_tx_ts_valid", tx_ts_valid == 1'b0, 64'(tx_ts_valid), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("tready_after_reset", tready == 1'b1, 64'(tready), 64'd1);

        for (int i = 0; i < 7; i++) begin
            rtc_run = 1'b0;
            rmode   = vt[i].rmode;
            rtc     = vt[i].rtc0;
            rtc_run = vt[i].run;
            send_frame(vt[i].len, vt[i].etype, vt[i].exp_match, vt[i].exp_ins, i * 17 + 1, vt[i].len);
            wait_drain();
            if (i == 0)
                chk("vec0_tx_ts", tx_ts == 64'h0011223344556677, tx_ts, 64'h0011223344556677);
        end

        // Three back-to-back frames with MAC ready toggling every cycle.
        rmode   = 1;
        rtc     = 64'h0000000000010000;
        rtc_run = 1'b1;
        send_frame(20, 16'h0800, 1'b0, 0, 3, 20);
        send_frame(60, 16'h88F7, 1'b1, 8, 5, 60);
        send_frame(30, 16'h88F7, 1'b1, 0, 9, 30);
        wait_drain();

        // Reset in the middle of a frame, then a fresh stamped frame.
        rmode = 0;
        send_frame(60, 16'h88F7, 1'b1, 8, 13, 21);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_tvalid", out_tvalid == 1'b0, 64'(out_tvalid), 64'd0);
        chk("midrst_out_tlast", out_tlast == 1'b0, 64'(out_tlast), 64'd0);
        chk("midrst_out_tdata", out_tdata == 8'd0, 64'(out_tdata), 64'd0);
        chk("midrst_tx_ts", tx_ts == 64'd0, tx_ts, 64'd0);
        chk("midrst_tready", tready == 1'b1, 64'(tready), 64'd1);
        exp_q.delete();
        rep_q.delete();
        cap_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(60, 16'h88F7, 1'b1, 8, 21, 60);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tsu_axis_tx_stamp.md
# tsu_axis_tx_stamp

Transmit-side timestamping stage between the TX client FIFO output and the tri-mode MAC `tx_axis_mac_*` input, in the `tx_mac_aclk` domain. Each frame is passed byte-for-byte through a 2-entry skid buffer. The block captures the RTC value when the MAC accepts the first byte of each frame and reports it per frame. For frames with the configured EtherType, it optionally overwrites 8 payload bytes with that timestamp (one-step PTP style).

## Interface
Parameters:
- `ETHERTYPE`, 16'h88F7, EtherType (bytes 12–13, big-endian) that qualifies a frame for stamping.
- `TS_OFFSET`, 48, byte index of the first overwritten byte. Legal range is 16..2039.

Ports:
- `mac_axis_aclk`  in  1  tx MAC clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `rtc_timer_in`  in  64  RTC time in ns, already synchronous to `mac_axis_aclk`.
- `mac_axis_tdata`  in  8  frame byte from the TX client FIFO.
- `mac_axis_tvalid`  in  1  upstream valid.
- `mac_axis_tlast`  in  1  last byte of the frame.
- `mac_axis_tready`  out  1  ready to upstream.
- `mac_axis_out_tdata`  out  8  byte to the MAC.
- `mac_axis_out_tvalid`  out  1  valid to the MAC.
- `mac_axis_out_tlast`  out  1  last byte to the MAC.
- `mac_axis_out_tready`  in  1  MAC ready.
- `tx_ts`  out  64  captured timestamp of the last completed frame.
- `tx_ts_match`  out  1  that frame matched `ETHERTYPE`.
- `tx_ts_valid`  out  1  one-cycle pulse marking that `tx_ts` and `tx_ts_match` are updated.

## Operation
- **Skid buffer.** 2 entries; each entry holds data and last.
  - `mac_axis_tready` = buffer not full.
  - Output is taken from the head entry.
  - Supports a push and a pop in the same cycle, giving full throughput.
- **Input byte counter** `in_cnt`, 11 bits.
  - Increments on each input handshake.
  - Saturates at 2047.
  - Clears to 0 after a handshake with tlast.
- **Output SOF flag.**
  - Set at reset and after an output handshake with tlast.
  - Cleared by any other output handshake.
- **Capture.** On an output handshake with SOF=1, `ts_cap <= rtc_timer_in`.
- **EtherType check.**
  - Input byte 12 is latched.
  - At byte 13, `match <= ({b12,b13} == ETHERTYPE)`.
  - `match` clears at the first byte of the next frame.
- **Insertion.** Applies only with the macro defined.
  - Condition: input bytes with `in_cnt` in [TS_OFFSET, TS_OFFSET+7] and `match`=1.
  - Those bytes are replaced at push time by `ts_cap[63-8k -: 8]`, where k = `in_cnt` − TS_OFFSET (MSB first).
  - Since TS_OFFSET ≥ 16 and buffer depth is 2, byte 0 of the same frame has already left the buffer before byte TS_OFFSET is pushed. `ts_cap` is therefore always the current frame's capture.
- **Frame completion.** On an output handshake with tlast:
  - `tx_ts <= ts_cap`.
  - `tx_ts_match <=` the frame's match.
  - `tx_ts_valid` pulses.
- **State machine** on the input side: IDLE → HDR (bytes 0–13) → BODY → IDLE on tlast.
  - INS is a BODY sub-range, not a separate state.
- **Boundary cases.**
  - tlast inside the stamp field: bytes up to tlast are replaced, nothing is appended, tlast is unchanged.
  - Frame shorter than 14 bytes: `match`=0.
  - Frame longer than 2047 bytes: the counter saturates and no second insertion occurs.
  - Back-to-back frames: the tlast byte and the next byte 0 may be in the buffer together, with no bubble.
- **Reset.** Assertion mid-frame drops buffered bytes. The next accepted input byte is treated as byte 0.

## Timing
- Reset values:
  - `mac_axis_out_tvalid`=0, `mac_axis_out_tlast`=0, `mac_axis_out_tdata`=0.
  - `mac_axis_tready`=1 on the first cycle after release.
  - `tx_ts`=0, `tx_ts_match`=0, `tx_ts_valid`=0.
- Latency: input handshake to `mac_axis_out_tvalid` is 1 cycle.
- Steady state: 1 byte/cycle while `mac_axis_out_tready`=1.
- `mac_axis_out_tdata`, `mac_axis_out_tvalid` and `mac_axis_out_tlast` are held stable while valid=1 and ready=0.
- `tx_ts_valid` is asserted in the cycle after the tlast output handshake, for exactly 1 cycle.

## Configuration
- `TSU_TX_INSERT_EN` defined: insertion active as described.
- Undefined:
  - Data passes unmodified.
  - Capture, `match` and the `tx_ts*` reporting remain.
  - Insertion logic and the byte-select mux are not built.

## Test plan
- 60-byte frame, EtherType 0x88F7, `rtc_timer_in`=64'h0011223344556677 at the byte-0 output handshake, MAC always ready:
  - Bytes 48–55 out are 00,11,…,77; all other bytes are unchanged.
  - `tx_ts_valid` pulses with `tx_ts_match`=1.
- 60-byte frame, EtherType 0x0800: output identical to input; `tx_ts_match`=0; `tx_ts` equals the capture value.
- 52-byte 0x88F7 frame: bytes 48–51 = ts[63:32]; tlast stays on byte 51; no extra bytes.
- MAC ready toggling 1/0 each cycle plus 3 back-to-back frames:
  - No byte lost or duplicated.
  - Each `tx_ts` equals the RTC at that frame's first accepted output byte.
- `rst` pulsed at byte 20 of a frame, then a fresh 0x88F7 frame:
  - Outputs go to reset values immediately.
  - The new frame is stamped at bytes 48–55.
- Build without `TSU_TX_INSERT_EN`, 0x88F7 frame: payload unmodified; `tx_ts_match`=1 and the `tx_ts_valid` pulse still occur.
